addr_decode_cfg: RTL and testbench

Runtime-programmable, registered address decoder for interconnect crossbars and demuxes. Holds a shadow rule table written over a simple config port and an active rule table used for decoding. A commit copies shadow to active only after in-flight decodes drain, so reconfiguration is atomic. Each rule selects range or NAPOT matching individually, and the decoder flags multi-rule hits and out-of-range target indices.

---
 rtl/addr_decode_cfg.sv | 212 +++++++++++++++++++++
 tb/tb_addr_decode_cfg.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/addr_decode_cfg.sv
// addr_decode_cfg
//   Runtime-programmable, registered address decoder. Config writes land in a
//   shadow rule table. A commit waits for the output register to drain, then
//   copies shadow -> active in one cycle, so every decode sees one consistent
//   table. Each rule is range or NAPOT; multiple hits and out-of-range target
//   indices are flagged.
//
// Ports
//   clk_i, rst_i          clock, synchronous active-high reset
//   cfg_we_i/rule/field/wdata  shadow-table write port (dropped while busy)
//   cfg_commit_i          request shadow -> active copy (accepted in IDLE only)
//   cfg_busy_o            commit pending or copying
//   en_default_idx_i, default_idx_i  miss / bad-index routing
//   req_valid_i/req_ready_o/req_addr_i        decode request
//   rsp_valid_o/rsp_ready_i/rsp_addr_o/rsp_idx_o/rsp_error_o/rsp_multi_o
//                         decode result, one cycle after accept
//   dbg_state_o           commit FSM state (0 IDLE, 1 DRAIN, 2 COPY)
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high. A valid source holds its payload stable until that edge; ready
// may depend combinationally on the sink's own state and the downstream ready.
module addr_decode_cfg #(
    parameter int unsigned NoIndices    = 8,
    parameter int unsigned NoRules      = 4,
    parameter int unsigned AddrWidth    = 32,
    parameter int unsigned IdxWidth     = (NoIndices > 1) ? $clog2(NoIndices) : 1,
    parameter int unsigned RuleIdxWidth = (NoRules > 1) ? $clog2(NoRules) : 1
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    cfg_we_i,
    input  logic [RuleIdxWidth-1:0] cfg_rule_i,
    input  logic [1:0]              cfg_field_i,
    input  logic [AddrWidth-1:0]    cfg_wdata_i,
    input  logic                    cfg_commit_i,
    output logic                    cfg_busy_o,
    input  logic                    en_default_idx_i,
    input  logic [IdxWidth-1:0]     default_idx_i,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic [AddrWidth-1:0]    req_addr_i,
    output logic                    rsp_valid_o,
    input  logic                    rsp_ready_i,
    output logic [AddrWidth-1:0]    rsp_addr_o,
    output logic [IdxWidth-1:0]     rsp_idx_o,
    output logic                    rsp_error_o,
    output logic                    rsp_multi_o,
    output logic [1:0]              dbg_state_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        COPY  = 2'd2
    } state_e;

    typedef struct packed {
        logic                 en;
        logic                 napot;
        logic [IdxWidth-1:0]  idx;
        logic [AddrWidth-1:0] start_addr;
        logic [AddrWidth-1:0] end_addr;   // end address, or mask in NAPOT mode
    } rule_t;

    // NoIndices always fits in IdxWidth+1 bits.
    localparam logic [IdxWidth:0] NoIdxLimit = NoIndices[IdxWidth:0];

    state_e              state_q, state_d;
    rule_t               shadow_q [NoRules];
    rule_t               active_q [NoRules];

    logic                rsp_valid_q;
    logic [AddrWidth-1:0] rsp_addr_q;
    logic [IdxWidth-1:0] rsp_idx_q;
    logic                rsp_error_q;
    logic                rsp_multi_q;

    logic                req_fire;
    logic                drain_done;
    logic [NoRules-1:0]  match;
    logic                hit;
    logic                multi;
    logic [IdxWidth-1:0] win_idx;
    logic [IdxWidth-1:0] dec_idx;
    logic                dec_error;

    // ---------------- commit FSM ----------------
    assign drain_done = !rsp_valid_q || rsp_ready_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cfg_commit_i) state_d = DRAIN;
            DRAIN:   if (drain_done)   state_d = COPY;
            COPY:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign cfg_busy_o  = (state_q != IDLE);
    assign dbg_state_o = state_q;
    // Gated by rst_i so the port reads 0 for the whole reset window.
    assign req_ready_o = !rst_i && (state_q == IDLE) && drain_done;
    assign req_fire    = req_valid_i && req_ready_o;

    // ---------------- rule tables ----------------
    // A write in the same cycle as an accepted commit still lands (state is
    // IDLE), so it is part of the copy two cycles later.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int r = 0; r < NoRules; r++) shadow_q[r] <= '0;
        end else if (cfg_we_i && (state_q == IDLE)) begin
            for (int r = 0; r < NoRules; r++) begin
                if (cfg_rule_i == RuleIdxWidth'(r)) begin
                    case (cfg_field_i)
                        2'd0: shadow_q[r].start_addr <= cfg_wdata_i;
                        2'd1: shadow_q[r].end_addr   <= cfg_wdata_i;
                        2'd2: begin
                            shadow_q[r].en    <= cfg_wdata_i[0];
                            shadow_q[r].napot <= cfg_wdata_i[1];
                            shadow_q[r].idx   <= cfg_wdata_i[2 +: IdxWidth];
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int r = 0; r < NoRules; r++) active_q[r] <= '0;
        end else if (state_q == COPY) begin
            for (int r = 0; r < NoRules; r++) active_q[r] <= shadow_q[r];
        end
    end

    // ---------------- decode ----------------
    always_comb begin
        match = '0;
        for (int r = 0; r < NoRules; r++) begin
            if (active_q[r].en) begin
                if (active_q[r].napot)
                    match[r] = ((active_q[r].start_addr & active_q[r].end_addr) ==
                                (req_addr_i & active_q[r].end_addr));
                else
                    match[r] = (req_addr_i >= active_q[r].start_addr) &&
                               ((req_addr_i < active_q[r].end_addr) ||
                                (active_q[r].end_addr == '0));
            end
        end
    end

    // Ascending scan: later matches overwrite, so the highest rule wins.
    always_comb begin
        hit     = 1'b0;
        multi   = 1'b0;
        win_idx = '0;
        for (int r = 0; r < NoRules; r++) begin
            if (match[r]) begin
                if (hit) multi = 1'b1;
                hit     = 1'b1;
                win_idx = active_q[r].idx;
            end
        end
    end

    always_comb begin
        dec_idx   = '0;
        dec_error = 1'b0;
        if (!hit) begin
            dec_error = !en_default_idx_i;
            dec_idx   = en_default_idx_i ? default_idx_i : '0;
        end else if ({1'b0, win_idx} >= NoIdxLimit) begin
            dec_error = 1'b1;
            dec_idx   = en_default_idx_i ? default_idx_i : '0;
        end else begin
            dec_idx   = win_idx;
        end
    end

    // ---------------- response register ----------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rsp_valid_q <= 1'b0;
            rsp_addr_q  <= '0;
            rsp_idx_q   <= '0;
            rsp_error_q <= 1'b0;
            rsp_multi_q <= 1'b0;
        end else if (req_fire) begin
            rsp_valid_q <= 1'b1;
            rsp_addr_q  <= req_addr_i;
            rsp_idx_q   <= dec_idx;
            rsp_error_q <= dec_error;
            rsp_multi_q <= multi;
        end else if (rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
        end
    end

    assign rsp_valid_o = rsp_valid_q;
    assign rsp_addr_o  = rsp_addr_q;
    assign rsp_idx_o   = rsp_idx_q;
    assign rsp_error_o = rsp_error_q;
    assign rsp_multi_o = rsp_multi_q;

endmodule

// File: tb/tb_addr_decode_cfg.sv
module tb_addr_decode_cfg;

    // Six targets so an out-of-range index (6) fits in the 3-bit idx field.
    localparam int unsigned NoIndices = 6;
    localparam int unsigned NoRules   = 4;
    localparam int unsigned AddrWidth = 32;
    localparam int unsigned IdxWidth  = 3;
    localparam int unsigned RuleIdxW  = 2;

    // ---------------- clock / reset ----------------
    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    always #5 clk_i = ~clk_i;

    logic                 cfg_we_i = 1'b0;
    logic [RuleIdxW-1:0]  cfg_rule_i = '0;
    logic [1:0]           cfg_field_i = '0;
    logic [AddrWidth-1:0] cfg_wdata_i = '0;
    logic                 cfg_commit_i = 1'b0;
    logic                 cfg_busy_o;
    logic                 en_default_idx_i = 1'b0;
    logic [IdxWidth-1:0]  default_idx_i = '0;
    logic                 req_valid_i = 1'b0;
    logic                 req_ready_o;
    logic [AddrWidth-1:0] req_addr_i = '0;
    logic                 rsp_valid_o;
    logic                 rsp_ready_i = 1'b1;
    logic [AddrWidth-1:0] rsp_addr_o;
    logic [IdxWidth-1:0]  rsp_idx_o;
    logic                 rsp_error_o;
    logic                 rsp_multi_o;
    logic [1:0]           dbg_state_o;

    addr_decode_cfg #(
        .NoIndices(NoIndices),
        .NoRules  (NoRules),
        .AddrWidth(AddrWidth)
    ) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .cfg_we_i        (cfg_we_i),
        .cfg_rule_i      (cfg_rule_i),
        .cfg_field_i     (cfg_field_i),
        .cfg_wdata_i     (cfg_wdata_i),
        .cfg_commit_i    (cfg_commit_i),
        .cfg_busy_o      (cfg_busy_o),
        .en_default_idx_i(en_default_idx_i),
        .default_idx_i   (default_idx_i),
        .req_valid_i     (req_valid_i),
        .req_ready_o     (req_ready_o),
        .req_addr_i      (req_addr_i),
        .rsp_valid_o     (rsp_valid_o),
        .rsp_ready_i     (rsp_ready_i),
        .rsp_addr_o      (rsp_addr_o),
        .rsp_idx_o       (rsp_idx_o),
        .rsp_error_o     (rsp_error_o),
        .rsp_multi_o     (rsp_multi_o),
        .dbg_state_o     (dbg_state_o)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail   = 0;
    logic [AddrWidth-1:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // All tasks start and end just after a falling edge.
    task automatic cfg_write(input int rule, input int field, input logic [31:0] data);
        cfg_we_i    = 1'b1;
        cfg_rule_i  = RuleIdxW'(rule);
        cfg_field_i = 2'(field);
        cfg_wdata_i = data;
        @(negedge clk_i);
        cfg_we_i    = 1'b0;
    endtask

    task automatic write_rule(input int rule, input logic [31:0] s, input logic [31:0] e,
                              input logic [31:0] ctl);
        cfg_write(rule, 0, s);
        cfg_write(rule, 1, e);
        cfg_write(rule, 2, ctl);
    endtask

    task automatic do_commit(input bit timed);
        int n;
        cfg_commit_i = 1'b1;
        @(negedge clk_i);
        cfg_commit_i = 1'b0;
        if (timed) begin
            check_eq("commit_drain_state", 32'(dbg_state_o), 32'd1);
            check_eq("commit_busy", 32'(cfg_busy_o), 32'd1);
            check_eq("commit_drain_ready", 32'(req_ready_o), 32'd0);
            @(negedge clk_i);
            check_eq("commit_copy_state", 32'(dbg_state_o), 32'd2);
            @(negedge clk_i);
            check_eq("commit_idle_state", 32'(dbg_state_o), 32'd0);
            check_eq("commit_idle_busy", 32'(cfg_busy_o), 32'd0);
        end else begin
            n = 0;
            while (cfg_busy_o && n < 10) begin
                @(negedge clk_i);
                n++;
            end
            check_eq("commit_done", 32'(cfg_busy_o), 32'd0);
        end
    endtask

    task automatic decode(input string tag, input logic [31:0] a, input int exp_idx,
                          input bit exp_err, input bit exp_multi);
        req_valid_i = 1'b1;
        req_addr_i  = a;
        #1;
        check_eq({tag, "_ready"}, 32'(req_ready_o), 32'd1);
        @(negedge clk_i);
        req_valid_i = 1'b0;
        check_eq({tag, "_valid"}, 32'(rsp_valid_o), 32'd1);
        check_eq({tag, "_addr"}, rsp_addr_o, a);
        check_eq({tag, "_idx"}, 32'(rsp_idx_o), 32'(exp_idx));
        check_eq({tag, "_err"}, 32'(rsp_error_o), 32'(exp_err));
        check_eq({tag, "_multi"}, 32'(rsp_multi_o), 32'(exp_multi));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        repeat (3) @(negedge clk_i);
        check_eq("rst_ready", 32'(req_ready_o), 32'd0);
        check_eq("rst_valid", 32'(rsp_valid_o), 32'd0);
        check_eq("rst_busy", 32'(cfg_busy_o), 32'd0);
        check_eq("rst_state", 32'(dbg_state_o), 32'd0);
        check_eq("rst_addr", rsp_addr_o, 32'd0);
        check_eq("rst_idx", 32'(rsp_idx_o), 32'd0);
        rst_i = 1'b0;
        #1;
        check_eq("post_rst_ready", 32'(req_ready_o), 32'd1);

        // 1. basic range hit; shadow writes invisible until commit
        write_rule(0, 32'h1000, 32'h2000, 32'hD);          // en, idx 3
        decode("pre_commit", 32'h1FFC, 0, 1'b1, 1'b0);
        do_commit(1'b1);
        decode("r0_top", 32'h1FFC, 3, 1'b0, 1'b0);
        decode("r0_start", 32'h1000, 3, 1'b0, 1'b0);
        decode("r0_end", 32'h2000, 0, 1'b1, 1'b0);
        decode("r0_below", 32'h0FFC, 0, 1'b1, 1'b0);

        // 2. overlap with NAPOT rule, top-of-space range
        write_rule(1, 32'h1000, 32'hFFFF_F000, 32'h17);    // en, napot, idx 5
        write_rule(2, 32'hF000_0000, 32'h0, 32'h5);        // en, idx 1, to top
        do_commit(1'b0);
        decode("overlap", 32'h1010, 5, 1'b0, 1'b1);
        decode("top_space", 32'hFFFF_FFFC, 1, 1'b0, 1'b0);
        decode("top_base", 32'hF000_0000, 1, 1'b0, 1'b0);
        decode("miss", 32'h3000, 0, 1'b1, 1'b0);

        // 3. bad index and default routing
        cfg_write(0, 2, 32'h19);                           // en, idx 6 (= NoIndices)
        cfg_write(1, 2, 32'h0);                            // disable NAPOT rule
        cfg_write(1, 3, 32'hFFFF_FFFF);                    // reserved field, ignored
        do_commit(1'b0);
        en_default_idx_i = 1'b1;
        default_idx_i    = 3'd2;
        decode("bad_idx_def", 32'h1800, 2, 1'b1, 1'b0);
        decode("miss_def", 32'h5000, 2, 1'b0, 1'b0);
        en_default_idx_i = 1'b0;
        decode("bad_idx_nodef", 32'h1800, 0, 1'b1, 1'b0);

        // 4. commit under backpressure; write during DRAIN dropped
        cfg_write(2, 2, 32'h11);                           // idx 4, shadow only
        rsp_ready_i = 1'b0;
        req_valid_i = 1'b1;
        req_addr_i  = 32'hF000_0010;
        @(negedge clk_i);
        req_valid_i = 1'b0;
        check_eq("bp_valid", 32'(rsp_valid_o), 32'd1);
        check_eq("bp_old_idx", 32'(rsp_idx_o), 32'd1);
        cfg_commit_i = 1'b1;
        @(negedge clk_i);
        cfg_commit_i = 1'b0;
        check_eq("bp_drain", 32'(dbg_state_o), 32'd1);
        check_eq("bp_ready", 32'(req_ready_o), 32'd0);
        check_eq("bp_busy", 32'(cfg_busy_o), 32'd1);
        cfg_we_i    = 1'b1;
        cfg_rule_i  = 2'd2;
        cfg_field_i = 2'd2;
        cfg_wdata_i = 32'hD;                               // idx 3, must be dropped
        @(negedge clk_i);
        cfg_we_i = 1'b0;
        check_eq("bp_drain_hold", 32'(dbg_state_o), 32'd1);
        check_eq("bp_valid_hold", 32'(rsp_valid_o), 32'd1);
        check_eq("bp_addr_hold", rsp_addr_o, 32'hF000_0010);
        @(negedge clk_i);
        check_eq("bp_drain_hold2", 32'(dbg_state_o), 32'd1);
        rsp_ready_i = 1'b1;
        @(negedge clk_i);
        check_eq("bp_copy", 32'(dbg_state_o), 32'd2);
        check_eq("bp_drained", 32'(rsp_valid_o), 32'd0);
        @(negedge clk_i);
        check_eq("bp_idle", 32'(dbg_state_o), 32'd0);
        decode("bp_new_table", 32'hF000_0010, 4, 1'b0, 1'b0);

        // 5. back-to-back throughput
        for (int i = 0; i <= 16; i++) begin
            if (i > 0) begin
                check_eq("b2b_valid", 32'(rsp_valid_o), 32'd1);
                check_eq("b2b_addr", rsp_addr_o, exp_q.pop_front());
                check_eq("b2b_idx", 32'(rsp_idx_o), 32'd4);
            end
            if (i < 16) begin
                req_valid_i = 1'b1;
                req_addr_i  = 32'hF000_0000 + 32'(i * 4);
                exp_q.push_back(req_addr_i);
                #1;
                check_eq("b2b_ready", 32'(req_ready_o), 32'd1);
            end else begin
                req_valid_i = 1'b0;
            end
            @(negedge clk_i);
        end
        check_eq("b2b_empty_valid", 32'(rsp_valid_o), 32'd0);
        check_eq("b2b_queue_empty", 32'(exp_q.size()), 32'd0);

        // 6. reset during DRAIN
        rsp_ready_i = 1'b0;
        req_valid_i = 1'b1;
        req_addr_i  = 32'h1800;
        @(negedge clk_i);
        req_valid_i  = 1'b0;
        cfg_commit_i = 1'b1;
        @(negedge clk_i);
        cfg_commit_i = 1'b0;
        check_eq("rst2_in_drain", 32'(dbg_state_o), 32'd1);
        rst_i = 1'b1;
        @(negedge clk_i);
        check_eq("rst2_busy", 32'(cfg_busy_o), 32'd0);
        check_eq("rst2_valid", 32'(rsp_valid_o), 32'd0);
        check_eq("rst2_ready", 32'(req_ready_o), 32'd0);
        rst_i       = 1'b0;
        rsp_ready_i = 1'b1;
        decode("rst2_miss", 32'hF000_0010, 0, 1'b1, 1'b0);
        en_default_idx_i = 1'b1;
        default_idx_i    = 3'd3;
        decode("rst2_miss_def", 32'h1800, 3, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Safety net against a stuck simulation.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
